// File: rtl/bus_grant_scheduler.sv
// Round-robin bus-tenure scheduler: a one-hot grant is held for a whole transaction,
// and an unlocked owner that overstays while others wait is asked to yield.
module bus_grant_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] requests,
  input  logic [NUM_REQ-1:0] lock,
  // "release" is a reserved word, so the owner's end-of-tenure pulse is named release_pulse.
  input  logic [NUM_REQ-1:0] release_pulse,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid,
  output logic               yield_req,
  output logic [CNT_W-1:0]   tenure
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    YIELD = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]   TEN_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]   TEN_PRE  = CNT_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]    ID_LAST  = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  state_t             state;
  state_t             state_next;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    rr_ptr_next;
  logic [NUM_REQ-1:0] grant_next;
  logic [ID_W-1:0]    grant_id_next;
  logic               grant_valid_next;
  logic               yield_req_next;
  logic [CNT_W-1:0]   tenure_next;

  logic [ID_W:0]      pick;
  logic               pick_found;
  logic [ID_W-1:0]    pick_id;
  logic               owner_req;
  logic               owner_rel;
  logic               owner_lock;
  logic               owner_done;
  logic               others_req;
  logic               yield_due;
  logic [ID_W-1:0]    ptr_after_owner;

  // First set request scanning circularly upward from ptr; MSB of the result flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [ID_W-1:0]    ptr);
    logic            found;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] pos_id;
    int              pos;
    found = 1'b0;
    idx   = {ID_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end else begin
        pos = pos;
      end
      pos_id = ID_W'(pos);
      if (!found && req[pos_id]) begin
        found = 1'b1;
        idx   = pos_id;
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  assign pick       = rr_pick(requests, rr_ptr);
  assign pick_found = pick[ID_W];
  assign pick_id    = pick[ID_W-1:0];

  // Only the current owner's lock/release/request bits matter; everyone else's are ignored.
  assign owner_req  = requests[grant_id];
  assign owner_rel  = release_pulse[grant_id];
  assign owner_lock = lock[grant_id];
  assign owner_done = owner_rel | ~owner_req;
  assign others_req = |(requests & ~grant);
  assign yield_due  = (tenure == TEN_PRE) & ~owner_lock & others_req;

  assign ptr_after_owner = (grant_id == ID_LAST) ? {ID_W{1'b0}} : (grant_id + ID_W'(1));

  // State register and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= {ID_W{1'b0}};
      grant       <= {NUM_REQ{1'b0}};
      grant_id    <= {ID_W{1'b0}};
      grant_valid <= 1'b0;
      yield_req   <= 1'b0;
      tenure      <= {CNT_W{1'b0}};
    end else begin
      state       <= state_next;
      rr_ptr      <= rr_ptr_next;
      grant       <= grant_next;
      grant_id    <= grant_id_next;
      grant_valid <= grant_valid_next;
      yield_req   <= yield_req_next;
      tenure      <= tenure_next;
    end
  end

  // Next-state and next-output logic of the tenure FSM.
  always_comb begin
    state_next       = state;
    rr_ptr_next      = rr_ptr;
    grant_next       = grant;
    grant_id_next    = grant_id;
    grant_valid_next = grant_valid;
    yield_req_next   = yield_req;
    tenure_next      = tenure;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next       = OWNED;
          grant_next       = ONE_HOT0 << pick_id;
          grant_id_next    = pick_id;
          grant_valid_next = 1'b1;
          yield_req_next   = 1'b0;
          tenure_next      = {CNT_W{1'b0}};
        end else begin
          state_next       = IDLE;
          grant_next       = {NUM_REQ{1'b0}};
          grant_id_next    = {ID_W{1'b0}};
          grant_valid_next = 1'b0;
          yield_req_next   = 1'b0;
          tenure_next      = {CNT_W{1'b0}};
        end
      end
      OWNED: begin
        // Release has priority over a yield that would fire on the same edge.
        if (owner_done) begin
          state_next       = GAP;
          rr_ptr_next      = ptr_after_owner;
          grant_next       = {NUM_REQ{1'b0}};
          grant_id_next    = {ID_W{1'b0}};
          grant_valid_next = 1'b0;
          yield_req_next   = 1'b0;
          tenure_next      = {CNT_W{1'b0}};
        end else if (yield_due) begin
          state_next     = YIELD;
          yield_req_next = 1'b1;
          tenure_next    = TEN_MAX;
        end else if (tenure == TEN_MAX) begin
          tenure_next = TEN_MAX;
        end else begin
          tenure_next = tenure + CNT_W'(1);
        end
      end
      YIELD: begin
        // A yield is never withdrawn: only the owner finishing ends it.
        if (owner_done) begin
          state_next       = GAP;
          rr_ptr_next      = ptr_after_owner;
          grant_next       = {NUM_REQ{1'b0}};
          grant_id_next    = {ID_W{1'b0}};
          grant_valid_next = 1'b0;
          yield_req_next   = 1'b0;
          tenure_next      = {CNT_W{1'b0}};
        end else begin
          state_next     = YIELD;
          yield_req_next = 1'b1;
          tenure_next    = TEN_MAX;
        end
      end
      GAP: begin
        state_next       = IDLE;
        grant_next       = {NUM_REQ{1'b0}};
        grant_id_next    = {ID_W{1'b0}};
        grant_valid_next = 1'b0;
        yield_req_next   = 1'b0;
        tenure_next      = {CNT_W{1'b0}};
      end
      default: begin
        state_next       = IDLE;
        rr_ptr_next      = {ID_W{1'b0}};
        grant_next       = {NUM_REQ{1'b0}};
        grant_id_next    = {ID_W{1'b0}};
        grant_valid_next = 1'b0;
        yield_req_next   = 1'b0;
        tenure_next      = {CNT_W{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_bus_grant_scheduler.sv
// Directed bench for bus_grant_scheduler: expected outputs are queued as each step is
// driven and compared one clock later.
module tb_bus_grant_scheduler;

  logic       clock;
  logic       reset;
  logic [3:0] requests;
  logic [3:0] lock;
  logic [3:0] release_pulse;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       yield_req;
  logic [4:0] tenure;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
    logic       y;
    logic [4:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  bus_grant_scheduler #(.NUM_REQ(4), .MAX_HOLD(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .requests      (requests),
    .lock          (lock),
    .release_pulse (release_pulse),
    .grant         (grant),
    .grant_id      (grant_id),
    .grant_valid   (grant_valid),
    .yield_req     (yield_req),
    .tenure        (tenure)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_out(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    vectors++;
    assert (grant === e.g) else begin
      miscompares++;
      $error("FAIL %s grant: observed %b expected %b", tag, grant, e.g);
    end
    vectors++;
    assert (grant_id === e.id) else begin
      miscompares++;
      $error("FAIL %s grant_id: observed %0d expected %0d", tag, grant_id, e.id);
    end
    vectors++;
    assert (grant_valid === e.v) else begin
      miscompares++;
      $error("FAIL %s grant_valid: observed %b expected %b", tag, grant_valid, e.v);
    end
    vectors++;
    assert (yield_req === e.y) else begin
      miscompares++;
      $error("FAIL %s yield_req: observed %b expected %b", tag, yield_req, e.y);
    end
    vectors++;
    assert (tenure === e.t) else begin
      miscompares++;
      $error("FAIL %s tenure: observed %0d expected %0d", tag, tenure, e.t);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] rq, input logic [3:0] lk,
                      input logic [3:0] rl, input logic [3:0] eg, input logic [1:0] eid,
                      input logic ey, input logic [4:0] et);
    requests      = rq;
    lock          = lk;
    release_pulse = rl;
    exp_q.push_back('{eg, eid, (eg != 4'b0000), ey, et});
    @(posedge clock);
    #1;
    check_out(tag);
  endtask

  task automatic reset_check(input string tag);
    exp_q.push_back('{4'b0000, 2'd0, 1'b0, 1'b0, 5'd0});
    check_out(tag);
  endtask

  task automatic do_reset();
    requests      = 4'b0000;
    lock          = 4'b0000;
    release_pulse = 4'b0000;
    reset         = 1'b0;
    #3;
    reset_check("reset");
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Requester 2 wins from reset and holds until tenure reads 15.
  task automatic own2_to15(input logic [3:0] rq, input logic [3:0] lk);
    step("grant2", 4'b0100, lk, 4'b0000, 4'b0100, 2'd2, 1'b0, 5'd0);
    for (int j = 1; j <= 15; j++) begin
      step("hold2", rq, lk, 4'b0000, 4'b0100, 2'd2, 1'b0, 5'(j));
    end
  endtask

  initial begin
    logic [3:0] oh;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;

    // Basic grant from rr_ptr=0, release, one GAP, next owner.
    do_reset();
    step("first_grant", 4'b0110, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b0, 5'd0);
    step("release1",    4'b0110, 4'b0000, 4'b0010, 4'b0000, 2'd0, 1'b0, 5'd0);
    step("gap1",        4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 5'd0);
    step("grant2",      4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0, 5'd0);
    step("release2",    4'b0100, 4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0, 5'd0);
    step("gap2",        4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 5'd0);
    step("idle",        4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 5'd0);

    // All requesting: order 0,1,2,3,0 with three-cycle tenures.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      step("rr_grant", 4'b1111, 4'b0000, 4'b0000, oh, 2'(k % 4), 1'b0, 5'd0);
      step("rr_ten1",  4'b1111, 4'b0000, 4'b0000, oh, 2'(k % 4), 1'b0, 5'd1);
      step("rr_ten2",  4'b1111, 4'b0000, 4'b0000, oh, 2'(k % 4), 1'b0, 5'd2);
      step("rr_rel",   4'b1111, 4'b0000, oh,      4'b0000, 2'd0, 1'b0, 5'd0);
      step("rr_gap",   4'b1111, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 5'd0);
    end

    // Yield at tenure 16; it survives others dropping and a late lock.
    do_reset();
    own2_to15(4'b1101, 4'b0000);
    step("yield_rise",  4'b1101, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1, 5'd16);
    step("yield_hold",  4'b1101, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1, 5'd16);
    step("yield_hold",  4'b1101, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1, 5'd16);
    step("yield_drop",  4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 5'd16);
    step("yield_lock",  4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 5'd16);
    step("yield_rel",   4'b1101, 4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0, 5'd0);
    step("yield_gap",   4'b1001, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 5'd0);
    step("after_yield", 4'b1001, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1'b0, 5'd0);

    // Locked owner: no yield, tenure saturates; non-owner release ignored.
    do_reset();
    own2_to15(4'b0101, 4'b0100);
    step("lock_sat",    4'b0101, 4'b0100, 4'b0001, 4'b0100, 2'd2, 1'b0, 5'd16);
    for (int j = 0; j < 3; j++) begin
      step("lock_hold", 4'b0101, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 5'd16);
    end
    step("lock_rel",    4'b0101, 4'b0100, 4'b0100, 4'b0000, 2'd0, 1'b0, 5'd0);
    step("lock_gap",    4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 5'd0);
    step("after_lock",  4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0, 5'd0);

    // Implicit release by dropping the request; rr_ptr moves to 2.
    do_reset();
    step("own1",        4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b0, 5'd0);
    step("own1_ten1",   4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b0, 5'd1);
    step("drop1",       4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 5'd0);
    step("drop_gap",    4'b0111, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 5'd0);
    step("ptr_is_2",    4'b0111, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b0, 5'd0);

    // Release on the same edge as the yield condition: release wins.
    do_reset();
    own2_to15(4'b0101, 4'b0000);
    step("rel_vs_yield", 4'b0101, 4'b0000, 4'b0100, 4'b0000, 2'd0, 1'b0, 5'd0);
    step("rvy_gap",      4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 5'd0);
    step("ptr_wrap",     4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0, 5'd0);

    // Asynchronous reset while in YIELD.
    do_reset();
    own2_to15(4'b0101, 4'b0000);
    step("yield_again", 4'b0101, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1, 5'd16);
    reset = 1'b0;
    #2;
    reset_check("async_reset");
    requests = 4'b0001;
    @(negedge clock);
    reset = 1'b1;
    step("post_reset",  4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_grant_scheduler.md
Name: bus_grant_scheduler

Overview:
- Round-robin bus-tenure scheduler that shares the coherence bus between NUM_REQ requesters (L1 caches plus the memory-side port).
- Grants are held for a whole transaction, not a single cycle.
- Tenure is bounded by a hold counter: an unlocked owner that exceeds MAX_HOLD cycles while others wait is asked to yield.
- It sits between the cache bus interfaces and the coherence controller, and supplies the registered grant, owner index and yield request.

Parameters:
NUM_REQ, 4, number of requesters; must be at least 2.
MAX_HOLD, 16, tenure cycles before a yield may be requested; must be at least 2.
ID_W, log2(NUM_REQ), width of the owner index.
CNT_W, log2(MAX_HOLD+1), width of the tenure counter.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset.
requests  in  NUM_REQ  level request per requester; held until granted.
lock  in  NUM_REQ  owner's bit forbids yield requests (atomic or RFO sequences).
release  in  NUM_REQ  one-cycle pulse from the owner ending its tenure.
grant  out  NUM_REQ  one-hot registered grant; all zero when the bus is free.
grant_id  out  ID_W  index of the current owner; 0 when idle.
grant_valid  out  1  high while any grant bit is set.
yield_req  out  1  high while the owner is asked to finish and release.
tenure  out  CNT_W  cycles elapsed in the current tenure; saturates at MAX_HOLD.

Behaviour:
- Reset (reset=0, asynchronous), all outputs and state clear:
  - grant=0, grant_id=0, grant_valid=0, yield_req=0, tenure=0.
  - Round-robin pointer rr_ptr=0; state=IDLE.
- States are IDLE, OWNED, YIELD and GAP.
- IDLE:
  - If any requests bit is set, select the first set bit scanning circularly from rr_ptr upward.
  - Next cycle: grant is one-hot on the winner, grant_id=winner, grant_valid=1, tenure=0, state=OWNED.
  - Latency from request to grant is 1 cycle when the bus is idle.
  - With no requests, stay in IDLE.
- OWNED:
  - tenure increments by 1 per cycle, saturating at MAX_HOLD.
  - release[grant_id]=1, or requests[grant_id]=0 (implicit release): go to GAP; grant=0, grant_valid=0, yield_req=0, rr_ptr=(grant_id+1) mod NUM_REQ.
  - Otherwise, if tenure==MAX_HOLD-1, lock[grant_id]=0, and any other requests bit is set: go to YIELD and set yield_req=1 on the same edge that tenure reaches MAX_HOLD.
  - lock or release asserted by a non-owner is ignored.
- YIELD:
  - grant is held and yield_req stays 1; tenure stays saturated.
  - Owner release or request drop: go to GAP with the same updates as from OWNED.
  - If all other requests drop while in YIELD, stay in YIELD until release. No yield cancellation.
  - If lock[grant_id] rises while in YIELD, ignore it; the yield stands.
- GAP:
  - Exactly one dead cycle with all outputs idle (tenure=0, grant_id=0), then IDLE.
  - Requests are not sampled in GAP, so the minimum owner-to-owner gap is 2 cycles: GAP, then IDLE arbitration.
- Simultaneous events:
  - Release and the yield condition in the same cycle: release wins, go to GAP, yield_req stays 0.
  - A single requester re-requesting immediately gets the bus again after GAP; rr_ptr wraps from NUM_REQ-1 to 0.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - yield_req implies grant_valid.
- Reset mid-tenure drops the grant asynchronously. The requester must re-request after reset deasserts.

Test Plan:
- After reset, requests=4'b0110 (rr_ptr=0) -> next cycle grant=4'b0010, grant_id=1. On release[1], GAP for one cycle, then grant=4'b0100.
- requests=4'b1111 with each owner releasing after 3 cycles -> grant order 0,1,2,3,0; each tenure shows tenure values 0,1,2 before release.
- MAX_HOLD=16, owner 2 holds with requests[0]=1 and lock=0 -> yield_req rises when tenure=16 (17th owned cycle). Release 5 cycles later -> GAP, then grant=4'b1000 if requests[3]=1, otherwise 4'b0001.
- Same as the previous scenario but lock[2]=1 -> yield_req never asserts; tenure saturates at 16 and holds; release proceeds normally.
- Owner 1 drops requests[1] without a release pulse -> GAP next cycle; rr_ptr=2.
- reset pulled low while in YIELD -> grant, yield_req and tenure clear immediately (before the next clock edge). After reset deasserts with requests=4'b0001 -> grant=4'b0001 one cycle later.
